// File: rtl/pe_cfg_pkg.sv
// Shared types, widths and helpers for the PE-array configuration scheduler.
package pe_cfg_pkg;

  localparam int unsigned KSIZE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SETTLE = 3'd4
  } pe_cfg_state_t;

  // A kernel must span at least one and at most every column of the array.
  function automatic logic ksize_legal(input logic [KSIZE_W-1:0] ksize,
                                       input int unsigned        num_col);
    return (ksize != '0) && (32'(ksize) <= num_col);
  endfunction

endpackage

// File: rtl/pe_cfg_timer.sv
// Loadable down-counter with zero flag; reloaded by the scheduler on each state entry.
module pe_cfg_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pe_cfg_sched.sv
// Kernel-size reconfiguration scheduler: drain, flush, wait idle, settle, re-enable.
// Optional feature macro: PE_CFG_TIMEOUT_EN (bounded waits in DRAIN and WAIT).
module pe_cfg_sched
  import pe_cfg_pkg::*;
#(
  parameter int unsigned NUM_COL       = 10,
  parameter int unsigned DEFAULT_KSIZE = 3,
  parameter int unsigned FLUSH_MIN     = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [KSIZE_W-1:0] cfg_kernel_size,
  output logic               cfg_done,
  output logic               cfg_err,
  input  logic               bus_busy,
  input  logic               flush_busy,
  input  logic               rst_busy,
  output logic               flush,
  output logic [KSIZE_W-1:0] kernel_size,
  output logic               run_en
);

  localparam int unsigned MAX_FS  = (FLUSH_MIN > SETTLE_CYCLES) ? FLUSH_MIN : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (TIMEOUT > MAX_FS) ? TIMEOUT : MAX_FS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  pe_cfg_state_t      r_state, w_state_nxt;
  logic [KSIZE_W-1:0] r_kernel_size, w_kernel_size_nxt;
  logic [KSIZE_W-1:0] r_req_ksize, w_req_ksize_nxt;
  logic               r_run_en, w_run_en_nxt;
  logic               r_cfg_done, w_cfg_done_nxt;
  logic               r_cfg_err, w_cfg_err_nxt;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;

  pe_cfg_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero_c   (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_kernel_size <= KSIZE_W'(DEFAULT_KSIZE);
      r_req_ksize   <= KSIZE_W'(DEFAULT_KSIZE);
      r_run_en      <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_kernel_size <= w_kernel_size_nxt;
      r_req_ksize   <= w_req_ksize_nxt;
      r_run_en      <= w_run_en_nxt;
      r_cfg_done    <= w_cfg_done_nxt;
      r_cfg_err     <= w_cfg_err_nxt;
    end
  end

  // Timer is loaded with (count - 1) on entry so zero marks the last cycle of the state.
  always_comb begin
    w_state_nxt       = r_state;
    w_kernel_size_nxt = r_kernel_size;
    w_req_ksize_nxt   = r_req_ksize;
    w_run_en_nxt      = r_run_en;
    w_cfg_done_nxt    = 1'b0;
    w_cfg_err_nxt     = 1'b0;
    w_tmr_load        = 1'b0;
    w_tmr_val         = '0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (ksize_legal(cfg_kernel_size, NUM_COL)) begin
            w_req_ksize_nxt = cfg_kernel_size;
            w_run_en_nxt    = 1'b0;
            w_state_nxt     = ST_DRAIN;
            w_tmr_load      = 1'b1;
            w_tmr_val       = CNT_W'(TIMEOUT - 1);
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!bus_busy) begin
          w_state_nxt       = ST_FLUSH;
          w_kernel_size_nxt = r_req_ksize;
          w_tmr_load        = 1'b1;
          w_tmr_val         = CNT_W'(FLUSH_MIN - 1);
        end
`ifdef PE_CFG_TIMEOUT_EN
        else if (w_tmr_zero) begin
          w_state_nxt   = ST_IDLE;
          w_cfg_err_nxt = 1'b1;
        end
`endif
      end
      ST_FLUSH: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(TIMEOUT - 1);
        end
      end
      ST_WAIT: begin
        if (!flush_busy && !rst_busy) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(SETTLE_CYCLES - 1);
        end
`ifdef PE_CFG_TIMEOUT_EN
        else if (w_tmr_zero) begin
          w_state_nxt   = ST_IDLE;
          w_cfg_err_nxt = 1'b1;
        end
`endif
      end
      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_state_nxt    = ST_IDLE;
          w_cfg_done_nxt = 1'b1;
          w_run_en_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cfg_ready   = (r_state == ST_IDLE);
  assign flush       = (r_state == ST_FLUSH);
  assign kernel_size = r_kernel_size;
  assign run_en      = r_run_en;
  assign cfg_done    = r_cfg_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_pe_cfg_sched.sv
// Randomized scoreboard bench for pe_cfg_sched against a cycle-timeline reference model.
module tb_pe_cfg_sched;

  localparam int NUM_COL       = 10;
  localparam int DEFAULT_KSIZE = 3;
  localparam int FLUSH_MIN     = 2;
  localparam int SETTLE_CYCLES = 4;

  logic       clk, rstn;
  logic       cfg_valid, cfg_ready, cfg_done, cfg_err;
  logic [7:0] cfg_kernel_size, kernel_size;
  logic       bus_busy, flush_busy, rst_busy, flush, run_en;

  pe_cfg_sched #(
    .NUM_COL(NUM_COL), .DEFAULT_KSIZE(DEFAULT_KSIZE), .FLUSH_MIN(FLUSH_MIN),
    .SETTLE_CYCLES(SETTLE_CYCLES), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_size(cfg_kernel_size), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .bus_busy(bus_busy), .flush_busy(flush_busy), .rst_busy(rst_busy),
    .flush(flush), .kernel_size(kernel_size), .run_en(run_en)
  );

  typedef struct {
    int cyc;
    bit err;
    int ks;
    bit run;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;

  // Timeline model: windows of cycles where flush is high / ready is low, and kernel switch point.
  int fl_lo = 1, fl_hi = 0, rdy_lo = 1, rdy_hi = 0;
  int ks_old = DEFAULT_KSIZE, ks_new = DEFAULT_KSIZE, ks_cyc = 0;
  int cur_ks = DEFAULT_KSIZE;
  bit cur_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_busy();
    bus_busy   = 1'($urandom_range(0, 1));
    flush_busy = 1'($urandom_range(0, 1));
    rst_busy   = 1'($urandom_range(0, 1));
  endtask

  // Monitor: per-cycle timeline checks plus scoreboard pops on done/err pulses.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn) begin
      chk("cfg_ready", int'(cfg_ready), (cyc >= rdy_lo && cyc <= rdy_hi) ? 0 : 1);
      chk("flush", int'(flush), (cyc >= fl_lo && cyc <= fl_hi) ? 1 : 0);
      chk("kernel_size", int'(kernel_size), (cyc >= ks_cyc) ? ks_new : ks_old);
      if (cfg_done || cfg_err) begin
        chk("done_err_exclusive", int'(cfg_done && cfg_err), 0);
        if (sb.size() == 0) begin
          chk("sb_unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_cycle", cyc, e.cyc);
          chk("sb_err", int'(cfg_err), int'(e.err));
          chk("sb_done", int'(cfg_done), int'(!e.err));
          chk("sb_kernel", int'(kernel_size), e.ks);
          chk("sb_run_en", int'(run_en), int'(e.run));
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        chk("sb_missing_pulse", cyc, e.cyc);
      end
    end
  end

  // Issue one request at the current cycle; b = bus_busy cycles in DRAIN, w = busy cycles in WAIT.
  task automatic req(input int ks, input int b, input int w, input bit sel_rst, input bit abort);
    int a, f0, w0, d;
    a = cyc;
    cfg_valid = 1'b1;
    cfg_kernel_size = 8'(ks);
    if (!(ks >= 1 && ks <= NUM_COL)) begin
      sb.push_back('{a + 1, 1'b1, cur_ks, cur_run});
      step();
      cfg_valid = 1'b0;
      return;
    end
    f0 = a + b + 2;
    w0 = f0 + FLUSH_MIN;
    d  = w0 + w + 1 + SETTLE_CYCLES;
    ks_old = cur_ks; ks_new = ks; ks_cyc = f0;
    fl_lo = f0; fl_hi = w0 - 1;
    rdy_lo = a + 1; rdy_hi = d - 1;
    if (!abort) begin
      sb.push_back('{d, 1'b0, ks, 1'b1});
      cur_ks = ks;
      cur_run = 1'b1;
    end
    for (int c = a + 1; c < d; c++) begin
      step();
      if (abort && c == f0) begin
        chk("flush_before_reset", int'(flush), 1);
        rstn = 1'b0;
        ks_old = DEFAULT_KSIZE; ks_new = DEFAULT_KSIZE; ks_cyc = 0;
        fl_lo = 1; fl_hi = 0; rdy_lo = 1; rdy_hi = 0;
        cur_ks = DEFAULT_KSIZE; cur_run = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("rst_flush", int'(flush), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_kernel", int'(kernel_size), DEFAULT_KSIZE);
        chk("rst_run_en", int'(run_en), 0);
        chk("rst_done", int'(cfg_done), 0);
        chk("rst_err", int'(cfg_err), 0);
        step();
        step();
        rstn = 1'b1;
        return;
      end
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_kernel_size = 8'($urandom);
      rand_busy();
      if (c <= a + b) bus_busy = 1'b1;
      else if (c == a + b + 1) bus_busy = 1'b0;
      if (c >= w0 && c < w0 + w) begin
        if (sel_rst) rst_busy = 1'b1;
        else flush_busy = 1'b1;
      end else if (c == w0 + w) begin
        flush_busy = 1'b0;
        rst_busy   = 1'b0;
      end
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cfg_valid = 1'b0;
      rand_busy();
    end
  endtask

  initial begin
    int ks;
    rstn = 1'b0;
    cfg_valid = 1'b0;
    cfg_kernel_size = 8'd0;
    bus_busy = 1'b0; flush_busy = 1'b0; rst_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(cfg_ready), 1);
    chk("reset_done", int'(cfg_done), 0);
    chk("reset_err", int'(cfg_err), 0);
    chk("reset_flush", int'(flush), 0);
    chk("reset_run_en", int'(run_en), 0);
    chk("reset_kernel", int'(kernel_size), DEFAULT_KSIZE);
    rstn = 1'b1;
    step();

    req(6, 0, 0, 1'b0, 1'b0);
    idle(2);
    req(4, 5, 0, 1'b0, 1'b0);
    req(5, 0, 20, 1'b0, 1'b0);
    req(0, 0, 0, 1'b0, 1'b0);
    req(11, 0, 0, 1'b0, 1'b0);
    req(5, 0, 0, 1'b0, 1'b0);
    req(10, 1, 3, 1'b1, 1'b0);
    req(1, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       ks = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(11, 255));
        default: ks = int'($urandom_range(1, NUM_COL));
      endcase
      req(ks, int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
          1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    req(7, 1, 0, 1'b0, 1'b1);
    req(8, 0, 0, 1'b0, 1'b0);
    idle(20);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
